// File: rtl/mult32x32_sched.sv
// Sequencer for a 32x32 unsigned multiply built from four 16x16 partial products.
// It arbitrates two requesters round-robin and drives an external accumulating arithmetic unit.
module mult32x32_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [63:0] result,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        a_sel,
  output logic        b_sel,
  output logic [1:0]  shift_sel,
  output logic        clr_prod,
  output logic        upd_prod,
  input  logic [63:0] product
);

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_e;

  state_e      state_q;
  logic        ptr_q;
  logic        owner_q;
  logic        gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
  logic [63:0] result_q;
  logic [31:0] mul_a_q, mul_b_q;
  logic        a_sel_q, b_sel_q, clr_q, upd_q;
  logic [1:0]  shift_q;

  logic req_any;
  logic sel_d;

  // With both requests the pointer decides; otherwise the lone requester wins.
  assign req_any = req0 | req1;
  assign sel_d   = (req0 & req1) ? ptr_q : req1;

  // Outputs are registered alongside the state: each state's controls are
  // loaded on the edge that enters it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      a_sel_q  <= 1'b0;
      b_sel_q  <= 1'b0;
      shift_q  <= 2'b00;
      clr_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values and the defaults here are overridden cleanly.
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      a_sel_q <= 1'b0;
      b_sel_q <= 1'b0;
      shift_q <= 2'b00;
      clr_q   <= 1'b0;
      upd_q   <= 1'b0;

      unique case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            result_q <= product;
            done0_q  <= ~owner_q;
            done1_q  <= owner_q;
          end
          if (req_any) begin
            state_q <= P0;
            busy_q  <= 1'b1;
            owner_q <= sel_d;
            ptr_q   <= ~sel_d;
            gnt0_q  <= ~sel_d;
            gnt1_q  <= sel_d;
            mul_a_q <= sel_d ? a1 : a0;
            mul_b_q <= sel_d ? b1 : b0;
            clr_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        P0: begin
          state_q <= P1;
          b_sel_q <= 1'b1;
          shift_q <= 2'b01;
          upd_q   <= 1'b1;
        end
        P1: begin
          state_q <= P2;
          a_sel_q <= 1'b1;
          shift_q <= 2'b01;
          upd_q   <= 1'b1;
        end
        P2: begin
          state_q <= P3;
          a_sel_q <= 1'b1;
          b_sel_q <= 1'b1;
          shift_q <= 2'b10;
          upd_q   <= 1'b1;
        end
        P3:      state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign a_sel     = a_sel_q;
  assign b_sel     = b_sel_q;
  assign shift_sel = shift_q;
  assign clr_prod  = clr_q;
  assign upd_prod  = upd_q;

endmodule

// File: tb/tb_mult32x32_sched.sv
// Bench for mult32x32_sched: models the accumulating arithmetic unit, checks
// control sequencing, arbitration, latency and results through a scoreboard.
module tb_mult32x32_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [63:0] product = '0;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [63:0] result;
  logic [31:0] mul_a, mul_b;
  logic        a_sel, b_sel, clr_prod, upd_prod;
  logic [1:0]  shift_sel;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        owner;
    logic [63:0] res;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] late_a;
    logic [63:0] exp;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb_e;
  vec_t tbl[7];

  mult32x32_sched dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy), .mul_a(mul_a), .mul_b(mul_b),
    .a_sel(a_sel), .b_sel(b_sel), .shift_sel(shift_sel),
    .clr_prod(clr_prod), .upd_prod(upd_prod), .product(product)
  );

  always #5 clk = ~clk;

  // Arithmetic unit: 16x16 partial product, shifted, loaded or accumulated.
  logic [15:0] ha, hb;
  logic [63:0] raw, pp;
  always_comb begin
    ha  = a_sel ? mul_a[31:16] : mul_a[15:0];
    hb  = b_sel ? mul_b[31:16] : mul_b[15:0];
    raw = 64'(ha) * 64'(hb);
    case (shift_sel)
      2'b00:   pp = raw;
      2'b01:   pp = raw << 16;
      default: pp = raw << 32;
    endcase
  end

  always @(posedge clk) begin
    if (clr_prod)      product <= pp;
    else if (upd_prod) product <= product + pp;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset) begin
      check("gnt_onehot", 64'(gnt0 & gnt1), 64'd0);
      if (done0 || done1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'({done1, done0}), 64'd0);
        end else begin
          sb_e = sb_q.pop_front();
          check("done_onehot", 64'(done0 & done1), 64'd0);
          check("done_owner", 64'(done1), 64'(sb_e.owner));
          check("result", result, sb_e.res);
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_result"}, result, 64'd0);
    check({name, "_operands"}, {mul_a, mul_b}, 64'd0);
    check({name, "_ctrl"},
          64'({gnt0, gnt1, done0, done1, busy, a_sel, b_sel, shift_sel, clr_prod, upd_prod}),
          64'd0);
  endtask

  // Single isolated operation: checks latency, control sequence, busy window,
  // operand hold against late operand changes, and the done pulse.
  task automatic run_op(input vec_t v);
    logic [5:0] ctl_exp [5];
    ctl_exp = '{6'b000010, 6'b010101, 6'b100101, 6'b111001, 6'b000000};
    @(negedge clk);
    check("busy_idle", 64'(busy), 64'd0);
    if (v.sel) begin req1 = 1'b1; a1 = v.a; b1 = v.b; end
    else       begin req0 = 1'b1; a0 = v.a; b0 = v.b; end
    sb_q.push_back('{owner: v.sel, res: v.exp});
    @(negedge clk);
    check("gnt_latency", 64'({gnt1, gnt0}), v.sel ? 64'd2 : 64'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    if (v.sel) a1 = v.late_a; else a0 = v.late_a;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        @(negedge clk);
        check("gnt_pulse", 64'({gnt1, gnt0}), 64'd0);
      end
      check("ctrl_seq", 64'({a_sel, b_sel, shift_sel, clr_prod, upd_prod}), 64'(ctl_exp[c]));
      check("busy_window", 64'(busy), 64'd1);
      check("operand_hold", {mul_a, mul_b}, {v.a, v.b});
    end
    @(negedge clk);
    check("done_latency", 64'({done1, done0}), v.sel ? 64'd2 : 64'd1);
    check("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 64'hFFFF_FFFE_0000_0001};
    tbl[1] = '{1'b0, 32'd7,         32'd6,         32'd9,         64'd42};
    tbl[2] = '{1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0001, 64'h0};
    tbl[3] = '{1'b1, 32'h0000_FFFF, 32'h0001_0001, 32'h0000_0005, 64'h0000_0000_FFFF_FFFF};
    tbl[4] = '{1'b1, 32'h1234_5678, 32'h0000_0002, 32'h0000_0000, 64'h0000_0000_2468_ACF0};
    tbl[5] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 64'h4000_0000_0000_0000};
    tbl[6] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0000_FFFF_FFFF};

    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b1;

    // Simultaneous requests after reset: requester 0 first, then 1 back-to-back.
    @(negedge clk);
    req0 = 1'b1; a0 = 32'd3;       b0 = 32'd5;
    req1 = 1'b1; a1 = 32'h1_0000;  b1 = 32'h1_0000;
    sb_q.push_back('{owner: 1'b0, res: 64'd15});
    sb_q.push_back('{owner: 1'b1, res: 64'h1_0000_0000});
    @(negedge clk);
    check("both_first_gnt", 64'({gnt1, gnt0}), 64'd1);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    check("both_second_gnt", 64'({gnt1, gnt0}), 64'd2);
    check("both_done0", 64'({done1, done0}), 64'd1);
    req1 = 1'b0;
    repeat (5) @(negedge clk);
    check("both_done1_5cyc", 64'({done1, done0}), 64'd2);
    @(negedge clk);
    check("both_idle", 64'(busy), 64'd0);

    // Fairness: req1 held, req0 raised in req1's P2 must win the next DONE.
    @(negedge clk);
    req1 = 1'b1; a1 = 32'hDEAD_BEEF; b1 = 32'd2;
    sb_q.push_back('{owner: 1'b1, res: 64'h1_BD5B_7DDE});
    @(negedge clk);
    check("fair_gnt1", 64'({gnt1, gnt0}), 64'd2);
    repeat (2) @(negedge clk);
    req0 = 1'b1; a0 = 32'h1234; b0 = 32'h10;
    sb_q.push_back('{owner: 1'b0, res: 64'h1_2340});
    sb_q.push_back('{owner: 1'b1, res: 64'h1_BD5B_7DDE});
    repeat (3) @(negedge clk);
    check("fair_gnt0", 64'({gnt1, gnt0}), 64'd1);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    check("fair_gnt1_again", 64'({gnt1, gnt0}), 64'd2);
    req1 = 1'b0;
    repeat (5) @(negedge clk);
    check("fair_last_done", 64'({done1, done0}), 64'd2);

    foreach (tbl[i]) run_op(tbl[i]);

    // Reset in P2 aborts the operation with no done pulse.
    @(negedge clk);
    req0 = 1'b1; a0 = 32'hFFFF_0000; b0 = 32'd3;
    @(negedge clk);
    check("abort_gnt", 64'({gnt1, gnt0}), 64'd1);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 64'({done1, done0}), 64'd0);
    end
    reset = 1'b1;
    run_op('{1'b0, 32'h0001_0003, 32'h0002_0005, 32'h0, 64'h0000_0002_000B_000F});

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
